// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit: registered, handshaked bus master between the control unit
// and the memory/MMIO fabric.
//
// It accepts one bus operation (IF, IF_CB, READ or WRITE) while idle. It then
// drives the memory port until mem_ready, or until the wait-state limit
// expires. Finally it raises done for one cycle and updates the result
// register for that operation.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_op                   requested operation (BUS_NONE = no request)
//   addr_in, wdata_in        address / write data, sampled on accept
//   busy                     access in flight; bus_op ignored while high
//   done, bus_err            one-cycle completion pulse, timeout flag
//   opcode, cb_opcode, rdata last IF / IF_CB / READ results
//   mem_req, mem_we          memory request and write strobe
//   mem_addr, mem_wdata      memory address and write data
//   mem_rdata, mem_ready     memory read data and completion
//   cycle_count              free-running cycle counter (wraps)
//   stall_count              REQ cycles without mem_ready (saturates)

package cpu_bus_pkg;
  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_IF    = 3'd1,
    BUS_IF_CB = 3'd2,
    BUS_READ  = 3'd3,
    BUS_WRITE = 3'd4
  } bus_opcode_t;
endpackage

module cpu_bus_unit
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_opcode_t       bus_op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              bus_err,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] cb_opcode,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int WCNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LIM_C = WCNT_W'(WAIT_LIMIT);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state_q, state_d;
  bus_opcode_t         op_q, op_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0]   cb_q, cb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic                finish;
  logic                load_res;
  logic [DATA_W-1:0]   res_val;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    opcode_d = opcode_q;
    cb_d     = cb_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cycle_d  = cycle_q + CNT_W'(1);
    stall_d  = stall_q;
    finish   = 1'b0;
    load_res = 1'b0;
    res_val  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus_op != BUS_NONE) begin
          state_d = S_REQ;
          op_d    = bus_op;
          wait_d  = '0;
          req_d   = 1'b1;
          we_d    = (bus_op == BUS_WRITE);
          addr_d  = addr_in;
          wdata_d = (bus_op == BUS_WRITE) ? wdata_in : '0;
        end
      end
      S_REQ: begin
        // Ready is checked before the limit so a late ready still completes.
        if (mem_ready) begin
          finish   = 1'b1;
          load_res = 1'b1;
          res_val  = mem_rdata;
        end else begin
          stall_d = sat_inc(stall_q);
          if ((WAIT_LIMIT != 0) && (wait_q == WAIT_LIM_C)) begin
            // Aborted access reads as a floating bus (all ones).
            finish   = 1'b1;
            err_d    = 1'b1;
            load_res = 1'b1;
            res_val  = '1;
          end else begin
            wait_d = wait_q + WCNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
    end

    if (load_res) begin
      case (op_q)
        BUS_IF:    opcode_d = res_val;
        BUS_IF_CB: cb_d     = res_val;
        BUS_READ:  rdata_d  = res_val;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= BUS_NONE;
      wait_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      opcode_q <= '0;
      cb_q     <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cycle_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      err_q    <= err_d;
      opcode_q <= opcode_d;
      cb_q     <= cb_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cycle_q  <= cycle_d;
      stall_q  <= stall_d;
    end
  end

  assign busy        = (state_q == S_REQ);
  assign done        = done_q;
  assign bus_err     = err_q;
  assign opcode      = opcode_q;
  assign cb_opcode   = cb_q;
  assign rdata       = rdata_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed bench for cpu_bus_unit with a scoreboard of expected completions.
module tb_cpu_bus_unit;
  import cpu_bus_pkg::*;

  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        rst;
  bus_opcode_t bus_op;
  logic [15:0] addr_in;
  logic [7:0]  wdata_in;
  logic        busy, done, bus_err;
  logic [7:0]  opcode, cb_opcode, rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [47:0] cycle_count, stall_count;

  cpu_bus_unit #(.ADDR_W(16), .DATA_W(8), .WAIT_LIMIT(WL), .CNT_W(48)) dut (
    .clk(clk), .rst(rst), .bus_op(bus_op), .addr_in(addr_in),
    .wdata_in(wdata_in), .busy(busy), .done(done), .bus_err(bus_err),
    .opcode(opcode), .cb_opcode(cb_opcode), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bus_opcode_t op;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  m_opcode = 8'h00, m_cb = 8'h00, m_rdata = 8'h00;
  logic [47:0] m_stall = 48'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_opcode"}, 64'(opcode), 64'(m_opcode));
    chk({tag, "_cb"}, 64'(cb_opcode), 64'(m_cb));
    chk({tag, "_rdata"}, 64'(rdata), 64'(m_rdata));
    chk({tag, "_stall"}, 64'(stall_count), 64'(m_stall));
  endtask

  // Issue one access from IDLE; mem_ready rises on REQ cycle index 'delay'
  // (negative = never). The expected outcome is queued before driving.
  task automatic access(input string tag, input bus_opcode_t op,
                        input logic [15:0] a, input logic [7:0] wd,
                        input int delay, input logic [7:0] rd);
    exp_t e;
    int   lat, nreq, exp_lat;
    logic got, reqbad;
    e.op   = op;
    e.err  = (delay < 0) || (delay > WL);
    e.data = e.err ? 8'hFF : rd;
    sb.push_back(e);
    exp_lat = e.err ? 2 + WL : 2 + delay;

    bus_op = op; addr_in = a; wdata_in = wd;
    tick();
    bus_op = BUS_NONE;
    lat = 1; nreq = 0; got = 1'b0; reqbad = 1'b0;
    while (!got && lat < 60) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== a ||
            mem_we !== (op == BUS_WRITE) ||
            mem_wdata !== ((op == BUS_WRITE) ? wd : 8'h00))
          reqbad = 1'b1;
        mem_ready = (nreq == delay);
        mem_rdata = (nreq == delay) ? rd : ~rd;
        nreq++;
        tick();
        lat++;
      end
    end
    mem_ready = 1'b0;

    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_req_cycles"}, 64'(nreq), 64'(exp_lat - 1));
    chk({tag, "_req_outputs_bad"}, 64'(reqbad), 64'd0);
    chk({tag, "_req_drop"}, 64'({mem_req, mem_we, mem_addr, mem_wdata, busy}), 64'd0);

    e = sb.pop_front();
    chk({tag, "_bus_err"}, 64'(bus_err), 64'(e.err));
    case (e.op)
      BUS_IF:    m_opcode = e.data;
      BUS_IF_CB: m_cb     = e.data;
      BUS_READ:  m_rdata  = e.data;
      default:   ;
    endcase
    m_stall += e.err ? 48'(WL + 1) : 48'(delay);
    check_results(tag);

    tick();
    chk({tag, "_done_pulse"}, 64'({done, bus_err}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; bus_op = BUS_NONE; addr_in = '0; wdata_in = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_ctrl", 64'({busy, done, bus_err, mem_req, mem_we}), 64'd0);
    chk("rst_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    check_results("rst");
    rst = 1'b0;

    access("if_zero_wait", BUS_IF, 16'h0100, 8'h00, 0, 8'h3E);
    access("write_3wait", BUS_WRITE, 16'hFF80, 8'hA5, 3, 8'h77);
    access("read_timeout", BUS_READ, 16'h4000, 8'h00, -1, 8'h00);
    access("read_ready_at_limit", BUS_READ, 16'h4001, 8'h00, WL, 8'h12);
    access("if_timeout", BUS_IF, 16'h0300, 8'h00, -1, 8'h00);
    access("ifcb_2wait", BUS_IF_CB, 16'h0301, 8'h00, 2, 8'h5C);

    // Back-to-back IF then IF_CB, with a stray READ pulse while busy.
    bus_op = BUS_IF; addr_in = 16'h0200;
    tick();
    chk("b2b_if_req", 64'({mem_req, busy, mem_addr}), 64'({2'b11, 16'h0200}));
    bus_op = BUS_READ; addr_in = 16'h0BAD;
    mem_ready = 1'b1; mem_rdata = 8'h11;
    tick();
    m_opcode = 8'h11;
    chk("b2b_if_done", 64'({done, bus_err, opcode}), 64'({2'b10, 8'h11}));
    bus_op = BUS_IF_CB; addr_in = 16'h0201; mem_rdata = 8'h22;
    tick();
    chk("b2b_cb_req", 64'({mem_req, mem_addr, done}), 64'({1'b1, 16'h0201, 1'b0}));
    bus_op = BUS_NONE;
    tick();
    m_cb = 8'h22;
    chk("b2b_cb_done", 64'({done, bus_err, cb_opcode}), 64'({2'b10, 8'h22}));
    mem_ready = 1'b0;
    tick();
    chk("b2b_no_extra", 64'({mem_req, busy, done}), 64'd0);
    check_results("b2b");

    // Reset during the second wait cycle of a READ.
    bus_op = BUS_READ; addr_in = 16'h1234;
    tick();
    bus_op = BUS_NONE;
    tick();
    chk("rstmid_busy", 64'({busy, mem_req}), 64'({2'b11}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_opcode = 8'h00; m_cb = 8'h00; m_rdata = 8'h00; m_stall = 48'd0;
    chk("rstmid_ctrl", 64'({busy, done, bus_err, mem_req, mem_we}), 64'd0);
    chk("rstmid_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    chk("rstmid_cycle", 64'(cycle_count), 64'd0);
    check_results("rstmid");
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rstmid_quiet", 64'({done, mem_req, busy}), 64'd0);
    end
    chk("rstmid_cycle_run", 64'(cycle_count), 64'd5);

    access("post_rst_read", BUS_READ, 16'h2000, 8'h00, 1, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
